axi_stream_insert_header: RTL and testbench

AXI_STREAM_INSERT_HEADER -- requirements
Module: axi_stream_insert_header

---
 rtl/axi_stream_insert_header.sv | 186 ++++++++++++++++++
 tb/tb_axi_stream_insert_header.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_insert_header.sv
// axi_stream_insert_header
//   Prepends a 1..N byte header (N = DATA_BYTE_WD) to an AXI-Stream packet
//   and repacks header + payload MSB-first into full output beats.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   valid_in/ready_in payload beat handshake; data_in/keep_in/last_in MSB-first
//   valid_out/...     registered output beat; ready_out from downstream
//   valid_insert/...  header handshake; data_insert holds the header in its
//                     low H bytes, H = byte_insert_cnt + 1; keep_insert unused
module axi_stream_insert_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
  output logic                    ready_insert
);

  localparam int N  = DATA_BYTE_WD;
  localparam int CW = $clog2(N + 1);  // holds a byte count 0..N

  typedef enum logic [1:0] {IDLE, DATA, FLUSH} state_e;

  // n ones, left-aligned (MSB-first byte enables)
  function automatic logic [N-1:0] lmask(input int n);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[N-1-i] = (i < n);
    return m;
  endfunction

  // n ones, right-aligned (selects the low n bytes)
  function automatic logic [N-1:0] rmask(input int n);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[i] = (i < n);
    return m;
  endfunction

  // byte enables -> bit mask
  function automatic logic [DATA_WD-1:0] bexp(input logic [N-1:0] k);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  state_e               state_q, state_d;
  logic [CW-1:0]        hlen_q, hlen_d;   // header length H, fixed per packet
  logic [CW-1:0]        rcnt_q, rcnt_d;   // valid residual bytes for the flush beat
  logic [DATA_WD-1:0]   res_q, res_d;     // residual R, right-aligned in H bytes
  logic [DATA_WD-1:0]   dout_q, dout_d;
  logic [N-1:0]         keep_q, keep_d;
  logic                 last_q, last_d;
  logic                 vout_q, vout_d;

  logic                 free;
  logic                 hdr_fire, beat_fire;
  logic [CW-1:0]        hlen_in, dcnt;
  logic [CW:0]          sum;
  logic [DATA_WD-1:0]   din_m, cat_top, flush_data;
  logic                 unused_keep_insert;

  assign unused_keep_insert = ^keep_insert;

  // Output register can take a new beat when empty or draining this cycle.
  assign free         = !vout_q || ready_out;
  assign ready_in     = (state_q == DATA) && free;
  assign ready_insert = (state_q == IDLE);
  assign hdr_fire     = valid_insert && ready_insert;
  assign beat_fire    = valid_in && ready_in;

  assign hlen_in = CW'(byte_insert_cnt) + CW'(1);

  always_comb begin
    dcnt = '0;
    for (int i = 0; i < N; i++) dcnt = dcnt + CW'(keep_in[i]);
    if (!last_in) dcnt = CW'(N);
  end

  assign sum = {1'b0, hlen_q} + {1'b0, dcnt};

  // Zero the unused tail of the last beat so stale bytes never reach data_out.
  assign din_m = last_in ? (data_in & bexp(keep_in)) : data_in;

  // Top N bytes of {R(H bytes), data_in}: bytes of R above H are shifted out.
  assign cat_top    = DATA_WD'({res_q, din_m} >> (32'(hlen_q) * 8));
  assign flush_data = res_q << ((N - int'(hlen_q)) * 8);

  always_comb begin
    state_d = state_q;
    hlen_d  = hlen_q;
    rcnt_d  = rcnt_q;
    res_d   = res_q;
    dout_d  = dout_q;
    keep_d  = keep_q;
    last_d  = last_q;
    vout_d  = vout_q && !ready_out;
    case (state_q)
      IDLE: begin
        if (hdr_fire) begin
          hlen_d  = hlen_in;
          res_d   = data_insert & bexp(rmask(int'(hlen_in)));
          state_d = DATA;
        end
      end
      DATA: begin
        if (beat_fire) begin
          vout_d = 1'b1;
          dout_d = cat_top;
          res_d  = din_m & bexp(rmask(int'(hlen_q)));
          if (!last_in) begin
            keep_d = '1;
            last_d = 1'b0;
          end else if (sum <= (CW+1)'(N)) begin
            keep_d  = lmask(int'(sum));
            last_d  = 1'b1;
            res_d   = '0;
            state_d = IDLE;
          end else begin
            // Header plus tail overflow one beat: spill the rest into FLUSH.
            keep_d  = '1;
            last_d  = 1'b0;
            rcnt_d  = CW'(sum - (CW+1)'(N));
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (free) begin
          vout_d  = 1'b1;
          dout_d  = flush_data;
          keep_d  = lmask(int'(rcnt_q));
          last_d  = 1'b1;
          res_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hlen_q  <= '0;
      rcnt_q  <= '0;
      res_q   <= '0;
      dout_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      vout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hlen_q  <= hlen_d;
      rcnt_q  <= rcnt_d;
      res_q   <= res_d;
      dout_q  <= dout_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      vout_q  <= vout_d;
    end
  end

  assign valid_out = vout_q;
  assign data_out  = dout_q;
  assign keep_out  = keep_q;
  assign last_out  = last_q;

endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Directed bench for axi_stream_insert_header (N = 4): a table of packets
// with hand-computed output beats, run with and without backpressure, plus
// hand-written reset, pre-header, stall and mid-packet reset sequences.
module tb_axi_stream_insert_header;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, last_in, ready_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        valid_out, last_out, ready_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        valid_insert, ready_insert;
  logic [31:0] data_insert;
  logic [3:0]  keep_insert;
  logic [1:0]  byte_insert_cnt;

  logic ready_ctl, bp_en;
  int   cyc;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [1:0]  cnt;
    logic [31:0] hdr;
    int          nin;
    logic [31:0] din[3];
    logic [3:0]  kin[3];
    int          nout;
    logic [31:0] dout[4];
    logic [3:0]  kout[4];
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t q[$];
  vec_t  vt[8];

  axi_stream_insert_header dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in),
    .last_in(last_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out),
    .last_out(last_out), .ready_out(ready_out),
    .valid_insert(valid_insert), .data_insert(data_insert),
    .keep_insert(keep_insert), .byte_insert_cnt(byte_insert_cnt),
    .ready_insert(ready_insert)
  );

  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      #1 cyc++;
    end
  end

  assign ready_out = bp_en ? (cyc % 3 != 0) : ready_ctl;

  // Record every output beat that is handed off at the next rising edge.
  always @(negedge clk)
    if (rst_n && valid_out && ready_out)
      q.push_back('{d: data_out, k: keep_out, l: last_out});

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [1:0] c, input logic [31:0] h, input int ni,
    input logic [31:0] d0, input logic [3:0] k0,
    input logic [31:0] d1, input logic [3:0] k1,
    input logic [31:0] d2, input logic [3:0] k2,
    input int no,
    input logic [31:0] o0, input logic [3:0] q0,
    input logic [31:0] o1, input logic [3:0] q1,
    input logic [31:0] o2, input logic [3:0] q2,
    input logic [31:0] o3, input logic [3:0] q3);
    vec_t v;
    v.cnt = c; v.hdr = h; v.nin = ni; v.nout = no;
    v.din[0] = d0; v.kin[0] = k0; v.din[1] = d1; v.kin[1] = k1;
    v.din[2] = d2; v.kin[2] = k2;
    v.dout[0] = o0; v.kout[0] = q0; v.dout[1] = o1; v.kout[1] = q1;
    v.dout[2] = o2; v.kout[2] = q2; v.dout[3] = o3; v.kout[3] = q3;
    return v;
  endfunction

  task automatic send_hdr(input logic [1:0] c, input logic [31:0] d);
    int n;
    valid_insert = 1'b1; byte_insert_cnt = c; data_insert = d; keep_insert = 4'h5;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ready_insert) break;
    end
    chk("hdr_handshake", 32'(ready_insert), 32'd1);
    @(posedge clk); #1;
    valid_insert = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ready_in) break;
    end
    chk("beat_handshake", 32'(ready_in), 32'd1);
    @(posedge clk); #1;
    valid_in = 1'b0; last_in = 1'b0;
  endtask

  task automatic chk_pkt(input vec_t v, input string tag);
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (q.size() >= v.nout) break;
    end
    repeat (3) @(negedge clk);
    chk($sformatf("%s nbeats", tag), 32'(q.size()), 32'(v.nout));
    for (int i = 0; i < v.nout; i++) begin
      if (i < q.size()) begin
        chk($sformatf("%s beat%0d data", tag, i), q[i].d, v.dout[i]);
        chk($sformatf("%s beat%0d keep", tag, i), 32'(q[i].k), 32'(v.kout[i]));
        chk($sformatf("%s beat%0d last", tag, i), 32'(q[i].l), 32'(i == v.nout - 1));
      end
    end
    q.delete();
    @(posedge clk); #1;
  endtask

  task automatic run_pkt(input vec_t v, input string tag);
    q.delete();
    send_hdr(v.cnt, v.hdr);
    for (int i = 0; i < v.nin; i++) send_beat(v.din[i], v.kin[i], i == v.nin - 1);
    chk_pkt(v, tag);
  endtask

  initial begin
    vec_t sv;
    //           cnt  header        nin  payload beats (data, keep)                       nout expected beats (data, keep)
    vt[0] = mk(2'd1, 32'h0000AABB, 2, 32'h11223344, 4'hF, 32'h55667700, 4'hE, 32'h0, 4'h0,
               3, 32'hAABB1122, 4'hF, 32'h33445566, 4'hF, 32'h77000000, 4'h8, 32'h0, 4'h0);
    vt[1] = mk(2'd3, 32'hDEADBEEF, 1, 32'h01020304, 4'hF, 32'h0, 4'h0, 32'h0, 4'h0,
               2, 32'hDEADBEEF, 4'hF, 32'h01020304, 4'hF, 32'h0, 4'h0, 32'h0, 4'h0);
    vt[2] = mk(2'd0, 32'h000000CC, 1, 32'h99000000, 4'h8, 32'h0, 4'h0, 32'h0, 4'h0,
               1, 32'hCC990000, 4'hC, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0, 4'h0);
    vt[3] = mk(2'd3, 32'h11223344, 3, 32'hAABBCCDD, 4'hF, 32'h55667788, 4'hF, 32'h99AABB00, 4'hC,
               4, 32'h11223344, 4'hF, 32'hAABBCCDD, 4'hF, 32'h55667788, 4'hF, 32'h99AA0000, 4'hC);
    vt[4] = mk(2'd2, 32'hFF112233, 1, 32'h44556677, 4'hF, 32'h0, 4'h0, 32'h0, 4'h0,
               2, 32'h11223344, 4'hF, 32'h55667700, 4'hE, 32'h0, 4'h0, 32'h0, 4'h0);
    vt[5] = mk(2'd0, 32'h123456AB, 1, 32'h12345678, 4'hC, 32'h0, 4'h0, 32'h0, 4'h0,
               1, 32'hAB123400, 4'hE, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0, 4'h0);
    vt[6] = mk(2'd1, 32'hFFFFCAFE, 1, 32'h12345678, 4'hC, 32'h0, 4'h0, 32'h0, 4'h0,
               1, 32'hCAFE1234, 4'hF, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0, 4'h0);
    vt[7] = mk(2'd0, 32'h00000001, 2, 32'h02030405, 4'hF, 32'h06070809, 4'hF, 32'h0, 4'h0,
               3, 32'h01020304, 4'hF, 32'h05060708, 4'hF, 32'h09000000, 4'h8, 32'h0, 4'h0);

    rst_n = 1'b0; bp_en = 1'b0; ready_ctl = 1'b1;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_insert = 1'b0; data_insert = '0; keep_insert = '0; byte_insert_cnt = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst valid_out", 32'(valid_out), 32'd0);
    chk("rst data_out", data_out, 32'd0);
    chk("rst keep_out", 32'(keep_out), 32'd0);
    chk("rst last_out", 32'(last_out), 32'd0);
    chk("rst ready_in", 32'(ready_in), 32'd0);
    chk("rst ready_insert", 32'(ready_insert), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Payload offered before any header must be held off
    valid_in = 1'b1; data_in = 32'h11223344; keep_in = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("prehdr%0d ready_in", i), 32'(ready_in), 32'd0);
      chk($sformatf("prehdr%0d valid_out", i), 32'(valid_out), 32'd0);
    end
    @(posedge clk); #1 valid_in = 1'b0;

    // Packet table, first at full throughput, then with backpressure
    for (int p = 0; p < 2; p++) begin
      bp_en = (p == 1);
      for (int i = 0; i < 8; i++) run_pkt(vt[i], $sformatf("p%0d v%0d", p, i));
    end
    bp_en = 1'b0; ready_ctl = 1'b1;

    // Downstream stall for 3 cycles with a beat pending upstream
    q.delete();
    ready_ctl = 1'b0;
    send_hdr(2'd1, 32'h0000AABB);
    send_beat(32'h11223344, 4'hF, 1'b0);
    valid_in = 1'b1; data_in = 32'h55667700; keep_in = 4'hE; last_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d valid_out", i), 32'(valid_out), 32'd1);
      chk($sformatf("stall%0d data_out", i), data_out, 32'hAABB1122);
      chk($sformatf("stall%0d keep_out", i), 32'(keep_out), 32'hF);
      chk($sformatf("stall%0d last_out", i), 32'(last_out), 32'd0);
      chk($sformatf("stall%0d ready_in", i), 32'(ready_in), 32'd0);
    end
    @(posedge clk); #1 ready_ctl = 1'b1;
    begin
      int n;
      for (n = 0; n < 100; n++) begin
        @(negedge clk);
        if (ready_in) break;
      end
      chk("stall beat_handshake", 32'(ready_in), 32'd1);
      @(posedge clk); #1 valid_in = 1'b0; last_in = 1'b0;
    end
    chk_pkt(vt[0], "stall");

    // Reset in the middle of a packet
    q.delete();
    send_hdr(2'd1, 32'h0000AABB);
    send_beat(32'h11223344, 4'hF, 1'b0);
    rst_n = 1'b0; valid_in = 1'b0;
    #1;
    chk("midrst valid_out", 32'(valid_out), 32'd0);
    chk("midrst ready_insert", 32'(ready_insert), 32'd1);
    chk("midrst ready_in", 32'(ready_in), 32'd0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("postrst ready_insert", 32'(ready_insert), 32'd1);
    @(posedge clk); #1;
    q.delete();
    run_pkt(vt[2], "postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
